// File: rtl/fib_pkg.sv
// Shared types and defaults for the Fibonacci request controller and its BCD converter.
package fib_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_CONV,
    ST_DONE
  } state_t;

  localparam int DW_DEF     = 20;
  localparam int IW_DEF     = 3;
  localparam int DIGITS_DEF = 7;

  // Width of a counter that must hold 0 .. n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one add-3/shift step per clock, DW steps per conversion.
module bin2bcd_seq
  import fib_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [DW-1:0]         bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  done
);

  localparam int NW = $clog2(DW + 1);

  logic [DW-1:0]       bin_q;
  logic [4*DIGITS-1:0] acc_q;
  logic [NW-1:0]       iter_q;
  logic [4*DIGITS-1:0] acc_adj;
  logic [4*DIGITS-1:0] acc_nxt;
  logic [DW-1:0]       bin_nxt;

  always_comb begin
    acc_adj = acc_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc_q[4*d +: 4] >= 4'd5)
        acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
    end
    acc_nxt = {acc_adj[4*DIGITS-2:0], bin_q[DW-1]};
    bin_nxt = {bin_q[DW-2:0], 1'b0};
  end

  // bcd_out is the result of the step in progress, so on the final step the
  // caller can register the finished value on the same edge.
  assign bcd_out = acc_nxt;
  assign done    = (iter_q == NW'(1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bin_q  <= '0;
      acc_q  <= '0;
      iter_q <= '0;
    end else if (load) begin
      bin_q  <= bin_in;
      acc_q  <= '0;
      iter_q <= NW'(DW);
    end else if (iter_q != '0) begin
      bin_q  <= bin_nxt;
      acc_q  <= acc_nxt;
      iter_q <= iter_q - NW'(1);
    end
  end

endmodule

// File: rtl/fib_request_ctrl.sv
// Initiator for the Fibonacci solver handshake: issues a request, waits for the
// result with a timeout, converts it to BCD and presents it with a valid pulse.
module fib_request_ctrl
  import fib_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int IW      = IW_DEF,
  parameter int DIGITS  = DIGITS_DEF,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                go,
  input  logic [IW-1:0]       n_in,
  input  logic                fib_ready,
  input  logic                fib_done_tick,
  input  logic [DW-1:0]       fib_f,
  output logic                fib_start,
  output logic [IW-1:0]       fib_i,
  output logic                busy,
  output logic                valid,
  output logic [4*DIGITS-1:0] bcd,
  output logic                timeout_err
);

  localparam int            CW      = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t              state;
  logic [CW-1:0]       to_cnt;
  logic                conv_load;
  logic                conv_done;
  logic [4*DIGITS-1:0] conv_bcd;

  assign conv_load = (state == ST_WAIT) && fib_done_tick;
  assign fib_start = (state == ST_REQ) && fib_ready;
  assign busy      = (state != ST_IDLE);

  bin2bcd_seq #(
    .DW     (DW),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (conv_load),
    .bin_in  (fib_f),
    .bcd_out (conv_bcd),
    .done    (conv_done)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      to_cnt      <= '0;
      fib_i       <= '0;
      valid       <= 1'b0;
      bcd         <= '0;
      timeout_err <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) begin
            fib_i       <= n_in;
            timeout_err <= 1'b0;
            to_cnt      <= '0;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Solver readiness takes priority over an expiring timeout.
          if (fib_ready) begin
            to_cnt <= '0;
            state  <= ST_WAIT;
          end else if (to_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + CW'(1);
          end
        end
        ST_WAIT: begin
          if (fib_done_tick) begin
            state <= ST_CONV;
          end else if (to_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + CW'(1);
          end
        end
        ST_CONV: begin
          if (conv_done) begin
            bcd   <= conv_bcd;
            valid <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_request_ctrl.sv
// Scoreboard bench for fib_request_ctrl with a behavioural Fibonacci solver model.
module tb_fib_request_ctrl;

  localparam int DW      = 20;
  localparam int IW      = 3;
  localparam int DIGITS  = 7;
  localparam int TIMEOUT = 1024;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                go = 1'b0;
  logic [IW-1:0]       n_in = '0;
  logic                fib_ready = 1'b0;
  logic                fib_done_tick = 1'b0;
  logic [DW-1:0]       fib_f = '0;
  logic                fib_start;
  logic [IW-1:0]       fib_i;
  logic                busy;
  logic                valid;
  logic [4*DIGITS-1:0] bcd;
  logic                timeout_err;

  fib_request_ctrl #(
    .DW(DW), .IW(IW), .DIGITS(DIGITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .n_in(n_in),
    .fib_ready(fib_ready), .fib_done_tick(fib_done_tick), .fib_f(fib_f),
    .fib_start(fib_start), .fib_i(fib_i), .busy(busy), .valid(valid),
    .bcd(bcd), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] fib_ref(input logic [IW-1:0] n);
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = DW'(1);
    logic [DW-1:0] t;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic logic [4*DIGITS-1:0] bcd_ref(input logic [DW-1:0] v);
    logic [4*DIGITS-1:0] r = '0;
    int x = int'(v);
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Solver model: busy for a few cycles after fib_start, then done_tick and ready.
  logic          ready_en = 1'b1;
  logic          done_en  = 1'b1;
  logic          ovr_en   = 1'b0;
  logic [DW-1:0] ovr_val  = '0;
  int            sol_cnt  = 0;
  logic [IW-1:0] sol_n    = '0;

  always @(posedge clk) begin
    fib_done_tick <= 1'b0;
    if (fib_start === 1'b1) begin
      sol_cnt   <= 3;
      sol_n     <= fib_i;
      fib_ready <= 1'b0;
    end else if (sol_cnt != 0) begin
      sol_cnt <= sol_cnt - 1;
      if (sol_cnt == 1 && done_en) begin
        fib_done_tick <= 1'b1;
        fib_f         <= ovr_en ? ovr_val : fib_ref(sol_n);
      end
    end else begin
      fib_ready <= ready_en;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [4*DIGITS-1:0] bcd;
    int                  cyc;
  } exp_t;
  exp_t exp_q[$];
  int   n_start = 0;
  int   n_valid = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (fib_start === 1'b1) n_start++;
      if (fib_done_tick) exp_q.push_back('{bcd: bcd_ref(fib_f), cyc: cyc});
      if (valid === 1'b1) begin
        exp_t e;
        n_valid++;
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("bcd_sb", 32'(bcd), 32'(e.bcd));
          check("latency", 32'(cyc - e.cyc), 32'(DW + 1));
        end
      end
    end
  end

  task automatic go_pulse(input logic [IW-1:0] n);
    @(negedge clk);
    go   = 1'b1;
    n_in = n;
    @(negedge clk);
    go   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin
      n++;
      @(negedge clk);
    end
    if (busy) check("idle_wait", 32'd0, 32'd1);
  endtask

  initial begin
    #(10 * 10000);
    $display("FAIL watchdog: simulation did not finish, cmp %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    int nb, s0, v0;
    logic [4*DIGITS-1:0] bcd_hold;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_fib_i", 32'(fib_i), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    check("rst_start", 32'(fib_start), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic request n=7
    s0 = n_start; v0 = n_valid;
    go_pulse(3'd7);
    check("fib_i_7", 32'(fib_i), 32'd7);
    check("busy_on", 32'(busy), 32'd1);
    wait_idle(200, nb);
    check("start_once", 32'(n_start - s0), 32'd1);
    check("valid_once", 32'(n_valid - v0), 32'd1);
    check("bcd_7", 32'(bcd), 32'h0000013);
    check("terr_7", 32'(timeout_err), 32'd0);

    // Back-to-back n=0 then n=1
    go_pulse(3'd0);
    wait_idle(200, nb);
    check("bcd_0", 32'(bcd), 32'h0000000);
    @(negedge clk);
    check("busy_between", 32'(busy), 32'd0);
    go_pulse(3'd1);
    wait_idle(200, nb);
    check("bcd_1", 32'(bcd), 32'h0000001);
    check("valid_count", 32'(n_valid - v0), 32'd3);

    // Boundary values from the solver
    ovr_en = 1'b1; ovr_val = 20'hFFFFF;
    go_pulse(3'd2);
    wait_idle(200, nb);
    check("bcd_max", 32'(bcd), 32'h1048575);
    ovr_val = 20'd99999;
    go_pulse(3'd2);
    wait_idle(200, nb);
    check("bcd_99999", 32'(bcd), 32'h0099999);
    ovr_en = 1'b0;

    // go activity while busy is ignored
    s0 = n_start; v0 = n_valid;
    go_pulse(3'd6);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      go   = ~go;
      n_in = 3'd3;
    end
    go = 1'b0;
    check("fib_i_hold", 32'(fib_i), 32'd6);
    wait_idle(200, nb);
    check("busy_start_once", 32'(n_start - s0), 32'd1);
    check("busy_valid_once", 32'(n_valid - v0), 32'd1);
    check("bcd_6", 32'(bcd), 32'h0000008);
    check("fib_i_end", 32'(fib_i), 32'd6);

    // Timeout in REQ
    ready_en = 1'b0;
    repeat (2) @(negedge clk);
    bcd_hold = bcd; s0 = n_start;
    go_pulse(3'd4);
    wait_idle(TIMEOUT + 50, nb);
    check("req_to_cycles", 32'(nb), 32'(TIMEOUT));
    check("req_terr", 32'(timeout_err), 32'd1);
    check("req_busy", 32'(busy), 32'd0);
    check("req_bcd", 32'(bcd), 32'(bcd_hold));
    check("req_nostart", 32'(n_start - s0), 32'd0);

    // Timeout in WAIT; go first clears the sticky flag
    ready_en = 1'b1; done_en = 1'b0;
    repeat (2) @(negedge clk);
    go_pulse(3'd4);
    check("terr_cleared", 32'(timeout_err), 32'd0);
    wait_idle(TIMEOUT + 50, nb);
    check("wait_to_cycles", 32'(nb), 32'(TIMEOUT + 1));
    check("wait_terr", 32'(timeout_err), 32'd1);
    check("wait_bcd", 32'(bcd), 32'(bcd_hold));
    done_en = 1'b1;
    repeat (6) @(negedge clk);

    // Reset during conversion
    v0 = n_valid;
    go_pulse(3'd6);
    nb = 0;
    while (!fib_done_tick && nb < 50) begin
      @(negedge clk);
      nb++;
    end
    check("done_seen", 32'(fib_done_tick), 32'd1);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_bcd", 32'(bcd), 32'd0);
    check("mid_rst_terr", 32'(timeout_err), 32'd0);
    repeat (30) @(negedge clk);
    check("mid_rst_novalid", 32'(n_valid - v0), 32'd0);
    go_pulse(3'd5);
    wait_idle(200, nb);
    check("bcd_5", 32'(bcd), 32'h0000005);
    repeat (3) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
